// File: rtl/mul_sequencer_pkg.sv
// Shared control-signal types: ALU opcodes and the multiply sequencer state encoding.
package ControlSignals;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } aluOperation_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mulSeqState_t;

endpackage

// File: rtl/mul_sequencer.sv
// Shift-and-add unsigned multiplier controller that borrows the shared execute-stage ALU.
// Optional MUL_SEQ_HIGH_EN adds the carry compare and the resultHigh_out port.
module mul_sequencer
  import ControlSignals::*;
#(
  parameter  int DATA_WIDTH_POW = 6,
  localparam int DATA_WIDTH     = 1 << DATA_WIDTH_POW
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] multiplicand_in,
  input  logic [DATA_WIDTH-1:0] multiplier_in,
  output logic                  resultValid_out,
  input  logic                  resultReady_in,
  output logic [DATA_WIDTH-1:0] result_out,
`ifdef MUL_SEQ_HIGH_EN
  output logic [DATA_WIDTH-1:0] resultHigh_out,
`endif
  output logic                  busy_out,
  output logic [DATA_WIDTH-1:0] aluOperand1_out,
  output logic [DATA_WIDTH-1:0] aluOperand2_out,
  output aluOperation_t         aluOp_out,
  input  logic [DATA_WIDTH-1:0] aluResult_in
);

  localparam logic [DATA_WIDTH_POW-1:0] LAST_STEP = '1;

  mulSeqState_t            state;
  logic [DATA_WIDTH-1:0]   hi;
  logic [DATA_WIDTH-1:0]   lo;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH_POW-1:0] count;
  logic                    carry;

  // The carry only ever lands in hi, so the low half stays exact without it.
`ifdef MUL_SEQ_HIGH_EN
  assign carry = (aluResult_in < hi);
`else
  assign carry = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            mcand <= multiplicand_in;
            count <= '0;
            hi    <= '0;
            if (multiplicand_in == '0 || multiplier_in == '0) begin
              lo    <= '0;
              state <= DONE;
            end else begin
              lo    <= multiplier_in;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          {hi, lo} <= {carry, aluResult_in, lo[DATA_WIDTH-1:1]};
          count    <= count + 1'b1;
          if (count == LAST_STEP) state <= DONE;
        end
        DONE: begin
          if (resultReady_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_out       = (state == IDLE);
  assign resultValid_out = (state == DONE);
  assign busy_out        = (state == BUSY);
  assign aluOp_out       = OP_ADD;
  assign aluOperand1_out = busy_out ? hi : '0;
  assign aluOperand2_out = (busy_out && lo[0]) ? mcand : '0;
  assign result_out      = resultValid_out ? lo : '0;
`ifdef MUL_SEQ_HIGH_EN
  assign resultHigh_out  = resultValid_out ? hi : '0;
`endif

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: vector table, scoreboard queue and corner-case sequences.
module tb_mul_sequencer;
  import ControlSignals::*;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, res_ready;
  logic          ready, res_valid, busy;
  logic [W-1:0]  a_i, b_i, res_lo, res_hi, op1, op2, alu_res;
  aluOperation_t alu_op;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           lat;
    int           busy_cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];

  // The shared ALU lives outside the sequencer; here it is a plain adder.
  assign alu_res = op1 + op2;

  mul_sequencer dut (
    .clk_in          (clk),
    .reset_in        (rst),
    .start_in        (start),
    .ready_out       (ready),
    .multiplicand_in (a_i),
    .multiplier_in   (b_i),
    .resultValid_out (res_valid),
    .resultReady_in  (res_ready),
    .result_out      (res_lo),
`ifdef MUL_SEQ_HIGH_EN
    .resultHigh_out  (res_hi),
`endif
    .busy_out        (busy),
    .aluOperand1_out (op1),
    .aluOperand2_out (op2),
    .aluOp_out       (alu_op),
    .aluResult_in    (alu_res)
  );

`ifndef MUL_SEQ_HIGH_EN
  assign res_hi = '0;
`endif

  task automatic checkv(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkv("alu_op_add", W'(alu_op), W'(OP_ADD));
      if (!busy) begin
        checkv("idle_operand1", op1, '0);
        checkv("idle_operand2", op2, '0);
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.lo = p[W-1:0];
    e.hi = p[2*W-1:W];
    if (a == '0 || b == '0) begin
      e.lat = 1;
      e.busy_cyc = 0;
    end else begin
      e.lat = 65;
      e.busy_cyc = 64;
    end
    return e;
  endfunction

  // Issue one request and wait for resultValid_out; the result is left pending.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_t e;
    int lat, bcyc;
    exp_q.push_back(model(a, b));
    checkv({tag, "_ready_before"}, W'(ready), W'(1));
    start = 1'b1;
    a_i = a;
    b_i = b;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = {$urandom, $urandom};
    b_i = {$urandom, $urandom};
    lat = 1;
    bcyc = 0;
    while (!res_valid && lat < 200) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    checkv({tag, "_latency"}, W'(lat), W'(e.lat));
    checkv({tag, "_busy_cycles"}, W'(bcyc), W'(e.busy_cyc));
    checkv({tag, "_result"}, res_lo, e.lo);
`ifdef MUL_SEQ_HIGH_EN
    checkv({tag, "_result_high"}, res_hi, e.hi);
`endif
  endtask

  task automatic finish_op(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkv({tag, "_ready_after"}, W'(ready), W'(1));
    checkv({tag, "_valid_after"}, W'(res_valid), W'(0));
  endtask

  initial begin
    vecs[0] = '{64'd3, 64'd5, 64'd15, 64'd0, 65};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2] = '{64'd0, 64'd123, 64'd0, 64'd0, 1};
    vecs[3] = '{64'd123, 64'd0, 64'd0, 64'd0, 1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'd1, 65};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'h4000_0000_0000_0000, 65};
    vecs[6] = '{64'h1_0000_0001, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};

    rst = 1'b1; start = 1'b0; res_ready = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    checkv("reset_ready", W'(ready), W'(1));
    checkv("reset_valid", W'(res_valid), W'(0));
    checkv("reset_busy", W'(busy), W'(0));
    checkv("reset_result", res_lo, '0);
    checkv("reset_result_high", res_hi, '0);
    checkv("reset_operand1", op1, '0);

    // Table vectors: constants cross-checked against the scoreboard model.
    for (int i = 0; i < 7; i++) begin
      exp_t m;
      m = model(vecs[i].a, vecs[i].b);
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      checkv($sformatf("vec%0d_table_lo", i), res_lo, vecs[i].lo);
`ifdef MUL_SEQ_HIGH_EN
      checkv($sformatf("vec%0d_table_hi", i), res_hi, vecs[i].hi);
`endif
      checkv($sformatf("vec%0d_table_model", i), m.lo, vecs[i].lo);
      finish_op($sformatf("vec%0d", i));
    end

    // Result held in DONE while the consumer stalls and start_in toggles.
    run_op(64'd6, 64'd7, "hold");
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      a_i = 64'd11;
      b_i = 64'd13;
      checkv("hold_valid", W'(res_valid), W'(1));
      checkv("hold_result", res_lo, 64'd42);
      checkv("hold_ready", W'(ready), W'(0));
      checkv("hold_busy", W'(busy), W'(0));
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkv("hold_result_end", res_lo, 64'd42);
    finish_op("hold");

    // Reset in the middle of BUSY discards the partial product.
    exp_q.push_back(model(64'd7, 64'd9));
    start = 1'b1; a_i = 64'd7; b_i = 64'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 30; i++) begin
      @(posedge clk); #1;
    end
    checkv("midreset_busy_before", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    checkv("midreset_ready", W'(ready), W'(1));
    checkv("midreset_busy", W'(busy), W'(0));
    checkv("midreset_valid", W'(res_valid), W'(0));
    checkv("midreset_result", res_lo, '0);
    checkv("midreset_operand1", op1, '0);
    checkv("midreset_operand2", op2, '0);
    repeat (3) begin
      @(posedge clk); #1;
      checkv("midreset_no_result", W'(res_valid), W'(0));
    end
    run_op(64'd2, 64'd2, "after_reset");
    finish_op("after_reset");

    // Random operands, occasionally zero to exercise the fast path.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) ra = '0;
      if ($urandom_range(0, 15) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) rb = rb & 64'hFF;
      run_op(ra, rb, "rand");
      finish_op("rand");
    end

    checkv("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle unsigned 64×64 multiplier controller that has no adder of its own. It sequences the shared ALU through one shift-and-add step per cycle. It sits beside the execute stage and owns the ALU operand/opcode inputs only while BUSY; the execute-stage mux selects its ALU outputs while `busy_out` is high. It accepts one operation at a time through a valid/ready handshake and holds its result until the consumer takes it.

## Interface
- `DATA_WIDTH_POW`, default 6: log2 of operand width; `DATA_WIDTH = 1 << DATA_WIDTH_POW` (64).
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `reset_in`  in  1  synchronous, active-high reset.
- `start_in`  in  1  request valid; operands are sampled when `start_in & ready_out`.
- `ready_out`  out  1  high only in IDLE.
- `multiplicand_in`  in  DATA_WIDTH  unsigned operand A.
- `multiplier_in`  in  DATA_WIDTH  unsigned operand B.
- `resultValid_out`  out  1  high only in DONE.
- `resultReady_in`  in  1  consumer accepts the result.
- `result_out`  out  DATA_WIDTH  low half of A×B.
- `resultHigh_out`  out  DATA_WIDTH  high half of A×B; present only with `MUL_SEQ_HIGH_EN`.
- `busy_out`  out  1  high only in BUSY; the ALU is owned by this block.
- `aluOperand1_out`, `aluOperand2_out`  out  DATA_WIDTH  drive ALU operands.
- `aluOp_out`  out  aluOperation_t  always OP_ADD.
- `aluResult_in`  in  DATA_WIDTH  combinational ALU result, returned in the same cycle.

## Operation
- Registers:
  - `hi` and `lo` (DATA_WIDTH each) hold the product.
  - `mcand` holds operand A.
  - `count` is DATA_WIDTH_POW bits.
  - State register.
- States:
  - IDLE: on accept, load `hi=0`, `lo=B`, `mcand=A`, `count=0`.
    - If A==0 or B==0, go to DONE with `hi=lo=0` (fast path).
    - Otherwise go to BUSY.
  - BUSY: each cycle drive `aluOperand1_out=hi` and `aluOperand2_out = lo[0] ? mcand : 0`.
    - Carry `c = (aluResult_in < hi)`, unsigned compare; the carry logic exists only with the macro, otherwise `c=0`.
    - Update `{hi,lo} <= {c, aluResult_in, lo} >> 1`.
    - `count++`.
    - When `count == DATA_WIDTH-1`, go to DONE after that step.
  - DONE: `result_out=lo` and `resultHigh_out=hi`, held stable. When `resultReady_in` is high, go to IDLE.
- Outside BUSY: ALU operand outputs are 0 and `aluOp_out=OP_ADD`.
- `start_in` is ignored outside IDLE. Operand inputs are don't-care except in the accept cycle.
- The low half is exact without the carry, because a carry never shifts into `lo`.

## Timing
- Reset values: state=IDLE, `ready_out=1`, `resultValid_out=0`, `busy_out=0`, `result_out=0`, `resultHigh_out=0`, ALU operands 0, `count=0`.
- Accept at cycle T:
  - `busy_out` is high T+1..T+64.
  - `resultValid_out` rises at T+65.
  - Fast path: `resultValid_out` at T+1, `busy_out` never asserts.
- DONE with `resultReady_in` high at cycle D gives IDLE and `ready_out=1` at D+1. A new request cannot be accepted at D; minimum issue interval is 66 cycles (2 on the fast path).
- `resultValid_out` stays high with `result_out` unchanged for as long as `resultReady_in` stays low.
- Reset in any state, including mid-BUSY: IDLE next cycle. The partial product is discarded, no result is produced, and the ALU is released immediately.
- All outputs are decoded from registers. The only combinational path is `aluResult_in` to the next-state registers.

## Configuration
- `MUL_SEQ_HIGH_EN` defined: `resultHigh_out` port and the carry compare are present, and the full 128-bit product is available.
- Not defined: no `resultHigh_out` port and no comparator; `c` is tied 0. `result_out` is still the exact low 64 bits; the internal `hi` register remains.

## Structure
- The `mulSeqState_t` enum (IDLE, BUSY, DONE) goes into the shared `ControlSignals` package. This block reuses `aluOperation_t` from that package.
- No sub-module. The ALU is instantiated outside and shared, not inside this block. The counter and registers are inline.

## Test plan
- A=3, B=5 accepted at T → `busy_out` high T+1..T+64, `result_out=15` and `resultHigh_out=0` at T+65.
- A=B=0xFFFF_FFFF_FFFF_FFFF → `result_out=0x1`; with the macro, `resultHigh_out=0xFFFF_FFFF_FFFF_FFFE`.
- A=0, B=123 → `resultValid_out` at T+1, result 0, `busy_out` never high.
- Hold `resultReady_in` low 10 cycles in DONE while `start_in` toggles → result stable, no accept; `ready_out` returns one cycle after the ready handshake.
- Assert `reset_in` at T+30 of A=7, B=9 → IDLE next cycle, all outputs at reset values. A new A=2, B=2 then yields 4.
- Random A/B, 200 runs → `{resultHigh_out, result_out}` equals the reference product. `aluOp_out==OP_ADD` always; ALU operands are 0 whenever `busy_out` is low.
